// File: rtl/reg_file_pkg.sv
// Shared constants and FSM state type for the 16-entry register file.
package reg_file_pkg;
    localparam int NREG      = 16;
    localparam int DEF_WIDTH = 16;
    localparam int CNT_W     = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;
endpackage

// File: rtl/onehot_chk.sv
// Classifies an N-bit select vector as all-zero, one-hot or multi-hot.
module onehot_chk #(
    parameter int N = 16
) (
    input  logic [N-1:0] i_vec,
    output logic         o_is_zero,
    output logic         o_is_onehot,
    output logic         o_is_multi
);
    logic [N-1:0] w_low_cleared;

    // v & (v-1) drops the lowest set bit; nothing left means at most one bit.
    assign w_low_cleared = i_vec & (i_vec - N'(1));
    assign o_is_zero     = (i_vec == '0);
    assign o_is_onehot   = !o_is_zero && (w_low_cleared == '0);
    assign o_is_multi    = !o_is_zero && (w_low_cleared != '0);
endmodule

// File: rtl/reg_file_16.sv
// 16 x WIDTH register file with one-hot write, dual combinational read and a
// sequential clear engine. Optional write-to-read bypass: REG_FILE_BYPASS_EN.
module reg_file_16
    import reg_file_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NREG  = reg_file_pkg::NREG
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREG-1:0]  we_oh,
    input  logic             wr_valid,
    input  logic [WIDTH-1:0] wdata,
    input  logic [3:0]       rs1,
    input  logic [3:0]       rs2,
    output logic [WIDTH-1:0] rd1,
    output logic [WIDTH-1:0] rd2,
    input  logic             clr_req,
    output logic             busy,
    output logic             err_multi
);
    logic [WIDTH-1:0] r_regs [NREG];
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_err;

    logic w_is_zero;
    logic w_is_onehot;
    logic w_is_multi;
    logic w_wr_ok;
    logic w_commit;

    onehot_chk #(.N(NREG)) u_chk (
        .i_vec       (we_oh),
        .o_is_zero   (w_is_zero),
        .o_is_onehot (w_is_onehot),
        .o_is_multi  (w_is_multi)
    );

    // Writes arriving during a clear are silently dropped, errors included.
    assign w_wr_ok  = wr_valid && !r_busy && !rst;
    assign w_commit = w_wr_ok && w_is_onehot;

`ifdef REG_FILE_BYPASS_EN
    assign rd1 = (w_commit && we_oh[rs1]) ? wdata : r_regs[rs1];
    assign rd2 = (w_commit && we_oh[rs2]) ? wdata : r_regs[rs2];
`else
    assign rd1 = r_regs[rs1];
    assign rd2 = r_regs[rs2];
`endif

    assign busy      = r_busy;
    assign err_multi = r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
            r_state <= IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            for (int i = 0; i < NREG; i++)
                if (w_commit && we_oh[i]) r_regs[i] <= wdata;
            if (w_wr_ok && w_is_multi) r_err <= 1'b1;

            case (r_state)
                IDLE: begin
                    if (clr_req) begin
                        r_state <= CLEAR;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                CLEAR: begin
                    r_regs[r_cnt] <= '0;
                    r_cnt         <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(NREG - 1)) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // The three classifier flags must be mutually exclusive.
    always_ff @(posedge clk) begin
        if (!rst) assert ((32'(w_is_zero) + 32'(w_is_onehot) + 32'(w_is_multi)) == 1);
    end
endmodule

// File: tb/tb_reg_file_16.sv
// Randomized + directed self-checking bench for reg_file_16 against an array model.
module tb_reg_file_16;
    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [15:0]   we_oh;
    logic          wr_valid;
    logic [W-1:0]  wdata;
    logic [3:0]    rs1, rs2;
    logic [W-1:0]  rd1, rd2;
    logic          clr_req;
    logic          busy, err_multi;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] m_reg [16];
    int           clr_left;
    bit           m_err;

    reg_file_16 #(.WIDTH(W), .NREG(16)) dut (
        .clk(clk), .rst(rst), .we_oh(we_oh), .wr_valid(wr_valid), .wdata(wdata),
        .rs1(rs1), .rs2(rs2), .rd1(rd1), .rd2(rd2), .clr_req(clr_req),
        .busy(busy), .err_multi(err_multi)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] exp_rd(input logic [3:0] a);
        logic [W-1:0] v;
        v = m_reg[a];
`ifdef REG_FILE_BYPASS_EN
        if (!rst && clr_left == 0 && wr_valid && $countones(we_oh) == 1 && we_oh[a]) v = wdata;
`endif
        return v;
    endfunction

    task automatic model_edge();
        int n;
        if (rst) begin
            for (int i = 0; i < 16; i++) m_reg[i] = '0;
            clr_left = 0;
            m_err    = 1'b0;
        end else if (clr_left > 0) begin
            m_reg[16 - clr_left] = '0;
            clr_left--;
        end else begin
            if (wr_valid) begin
                n = $countones(we_oh);
                if (n == 1) begin
                    for (int i = 0; i < 16; i++) if (we_oh[i]) m_reg[i] = wdata;
                end else if (n > 1) m_err = 1'b1;
            end
            if (clr_req) clr_left = 16;
        end
    endtask

    // Drive one cycle, check reads before the edge and flags after it.
    task automatic cycle(input bit r, input bit v, input bit c, input logic [15:0] oh,
                         input logic [W-1:0] d, input logic [3:0] a1, input logic [3:0] a2);
        rst = r; wr_valid = v; clr_req = c; we_oh = oh; wdata = d; rs1 = a1; rs2 = a2;
        #3;
        chk("rd1", 32'(rd1), 32'(exp_rd(a1)));
        chk("rd2", 32'(rd2), 32'(exp_rd(a2)));
        @(posedge clk);
        model_edge();
        #1;
        chk("busy", 32'(busy), 32'(clr_left > 0));
        chk("err_multi", 32'(err_multi), 32'(m_err));
    endtask

    task automatic idle(input logic [3:0] a1, input logic [3:0] a2);
        cycle(0, 0, 0, 16'h0, '0, a1, a2);
    endtask

    task automatic sweep();
        for (int i = 0; i < 8; i++) idle(4'(2 * i), 4'(2 * i + 1));
    endtask

    task automatic wr(input int idx, input logic [W-1:0] d);
        cycle(0, 1, 0, 16'(1) << idx, d, 4'(idx), 4'(idx));
    endtask

    task automatic fill();
        for (int i = 0; i < 16; i++) wr(i, W'(16'h1111 * (i + 1)) | 16'h0001);
    endtask

    int busy_cnt;
    logic [15:0] oh_r;

    initial begin
        rst = 1'b1; wr_valid = 0; clr_req = 0; we_oh = '0; wdata = '0; rs1 = '0; rs2 = '0;
        for (int i = 0; i < 16; i++) m_reg[i] = '0;
        clr_left = 0; m_err = 0;
        @(posedge clk); #1;
        // Reset state
        cycle(1, 0, 0, 16'h0, '0, 4'd0, 4'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err_multi), 32'd0);
        sweep();

        // Single write to reg 3
        cycle(0, 1, 0, 16'h0008, 16'hA5A5, 4'd0, 4'd4);
        rs1 = 4'd3; #1;
        chk("wr_a5a5", 32'(rd1), 32'h0000A5A5);
        sweep();

        // Zero select is a no-op, multi-hot raises sticky error
        cycle(0, 1, 0, 16'h0000, 16'hFFFF, 4'd3, 4'd0);
        chk("zero_sel_err", 32'(err_multi), 32'd0);
        cycle(0, 1, 0, 16'h0011, 16'hBEEF, 4'd0, 4'd4);
        chk("multi_err", 32'(err_multi), 32'd1);
        sweep();
        chk("multi_sticky", 32'(err_multi), 32'd1);
        cycle(1, 0, 0, 16'h0, '0, 4'd0, 4'd0);

        // Clear sequence length and write dropped during busy
        fill();
        cycle(0, 0, 1, 16'h0, '0, 4'd0, 4'd15);
        busy_cnt = 0;
        for (int k = 0; k < 40 && busy; k++) begin
            busy_cnt++;
            if (k == 3) cycle(0, 1, 0, 16'h0020, 16'hDEAD, 4'd5, 4'd15);
            else if (k == 4) cycle(0, 1, 1, 16'h0101, 16'hDEAD, 4'd5, 4'd8);
            else idle(4'(k), 4'd5);
        end
        chk("busy_len", 32'(busy_cnt), 32'd16);
        chk("no_err_busy", 32'(err_multi), 32'd0);
        sweep();

        // Reset at cycle 5 of clear, then write reg 7
        fill();
        cycle(0, 0, 1, 16'h0, '0, 4'd0, 4'd1);
        for (int k = 0; k < 5; k++) idle(4'(k), 4'd15);
        cycle(1, 0, 0, 16'h0, '0, 4'd6, 4'd15);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        sweep();
        wr(7, 16'h7777);
        rs1 = 4'd7; #1;
        chk("wr7_after_rst", 32'(rd1), 32'h00007777);

        // Write and clear in the same idle cycle
        cycle(0, 1, 1, 16'h0200, 16'h9999, 4'd9, 4'd7);
        for (int k = 0; k < 20 && busy; k++) idle(4'd9, 4'd7);
        sweep();

        // Bypass vs. registered read on rs2
        wr(2, 16'h1111);
        cycle(0, 1, 0, 16'h0004, 16'h1234, 4'd0, 4'd2);
        idle(4'd0, 4'd2);
        chk("rd2_next", 32'(rd2), 32'h00001234);

        // Randomized traffic
        for (int k = 0; k < 800; k++) begin
            int sel;
            logic [15:0] oh;
            sel = int'($urandom_range(0, 99));
            if (sel < 50) oh = 16'(1) << $urandom_range(0, 15);
            else if (sel < 65) oh = 16'h0;
            else begin
                oh_r = 16'($urandom);
                oh = oh_r | (16'(1) << $urandom_range(0, 7)) | (16'(1) << $urandom_range(8, 15));
            end
            cycle($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 80,
                  $urandom_range(0, 99) < 4, oh, W'($urandom),
                  4'($urandom), 4'($urandom));
        end
        sweep();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule
